rsa_modexp_core: RTL
====================

// Module: rsa_modexp_core
// PURPOSE
//   Consumer side of the key path: computes result = message^exponent mod modulus,
//   i.e. RSA encryption with e_key or decryption with d_key held by the KeyManager.
//   Right-to-left square-and-multiply; each modular product is computed bit-serially
//   by interleaved add/reduce, with no IP cores. One operation in flight; start/ready handshake in,
//   one-cycle result_valid pulse out, matching the keys_valid style of the key path.
// PARAMETERS
//   WIDTH  32  operand width in bits (message, exponent, modulus, result)
// PORTS
//   clk           in   1      clock, all logic on rising edge
//   rst           in   1      synchronous, active-high reset
//   start         in   1      request; accepted only in a cycle where ready=1
//   message       in   WIDTH  base, sampled on accept
//   exponent      in   WIDTH  e_key or d_key, sampled on accept
//   modulus       in   WIDTH  n, sampled on accept
//   ready         out  1      high in IDLE only
//   result_valid  out  1      one-cycle pulse; result/err valid in that cycle only
//   result        out  WIDTH  message^exponent mod modulus; 0 when not valid
//   err           out  1      operand error, qualified by result_valid
// BEHAVIOUR
// - Reset: state IDLE, ready=1, result_valid=0, result=0, err=0. rst mid-operation
//   aborts at once: no result_valid is produced and all operand registers are cleared.
// - States: IDLE -> LOAD -> (MULT <-> NEXT)* -> DONE -> IDLE.
// - IDLE: on start&ready, capture operands into registers, go to LOAD. start while busy is ignored.
// - LOAD (1 clk): if modulus<2 or message>=modulus, go to DONE with err=1, result=0.
//   Else R=1, B=message, E=exponent. If E==0, go to DONE (result=1). Else go to MULT.
// - MULT (WIDTH clks): scan the bits of B MSB-first, i = WIDTH-1..0. Two units run in
//   parallel: P1 tracks R*B and P2 tracks B*B, both start at 0.
//   Per cycle: t=2P; if t>=n then t-=n; if B[i] then t+=a; if t>=n then t-=n.
//   a=R for P1 and a=B for P2. Intermediates are WIDTH+2 bits, so there is no overflow
//   when n is near 2^WIDTH. P stays in [0,n) after every cycle.
// - NEXT (1 clk): if E[0] then R=P1; B=P2; E=E>>1. If the new E==0, go to DONE; else go to MULT.
// - DONE (1 clk): result_valid=1, result=R (or 0 on err), then go to IDLE with ready=1.
// - Latency: with k = (index of highest set bit of exponent)+1, and k=0 for exponent 0,
//   result_valid is high exactly 2+(WIDTH+1)*k cycles after the accept cycle. The error case
//   takes 2 cycles. Worst case is 2+33*32=1058 cycles.
// - A new start is accepted in the cycle after DONE (back-to-back, no extra idle cycle).
// - Outside the pulse: result=0, err=0.
// TESTING
// 1. m=4, e=13, n=497 -> result=445, err=0, result_valid at accept+134.
// 2. m=65, e=17, n=3233 -> result=2790 at accept+167. Then m=2790, e=2753, n=3233 -> result=65 at +398.
// 3. e=0, m=7, n=11 -> result=1 at accept+2. m=11, n=11 -> err=1, result=0 at accept+2.
//    n=1 -> err=1.
// 4. Wide modulus: m=0xFFFFFFFA, e=2, n=0xFFFFFFFB -> result=1 at accept+68, no overflow.
// 5. start pulsed again at accept+10 with other operands -> ignored. Only the first result
//    is produced and ready stays 0 until DONE.
// 6. rst at accept+50 of case 2 -> no result_valid. Next cycle ready=1, outputs 0.
//    A fresh case 1 then completes correctly.
// 7. Random regression: 10k random operands (n>=2, m<n) checked against a software model
//    for result and exact latency.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation (message^exponent mod modulus), right-to-left square-and-multiply.
// Each modular product is formed bit-serially by interleaved double/add/reduce steps.
module rsa_modexp_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             ready,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_MULT = 3'd2,
                         S_NEXT = 3'd3, S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, b_q, b_d, e_q, e_d, r_q, r_d, p1_q, p1_d, p2_q, p2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  // One MSB-first step of p*x mod n: p' = (2p + bit*a) mod n, two extra bits of headroom.
  function automatic logic [WIDTH-1:0] mod_step(input logic [WIDTH-1:0] p,
      input logic [WIDTH-1:0] a, input logic bit_i, input logic [WIDTH-1:0] n);
    logic [WIDTH+1:0] t, nn;
    nn = {2'b00, n};
    t  = {1'b0, p, 1'b0};
    if (t >= nn) t = t - nn;
    if (bit_i) t = t + {2'b00, a};
    if (t >= nn) t = t - nn;
    return t[WIDTH-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    n_d = n_q; b_d = b_q; e_d = e_q; r_d = r_q;
    p1_d = p1_q; p2_d = p2_q; cnt_d = cnt_q; err_d = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        n_d = modulus; b_d = message; e_d = exponent;
        r_d = '0; err_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        p1_d = '0; p2_d = '0; cnt_d = CW'(WIDTH - 1);
        if (n_q < WIDTH'(2) || b_q >= n_q) begin
          err_d = 1'b1; r_d = '0; state_d = S_DONE;
        end else begin
          r_d = WIDTH'(1);
          state_d = (e_q == '0) ? S_DONE : S_MULT;
        end
      end
      S_MULT: begin
        p1_d = mod_step(p1_q, r_q, b_q[cnt_q], n_q);
        p2_d = mod_step(p2_q, b_q, b_q[cnt_q], n_q);
        if (cnt_q == '0) state_d = S_NEXT;
        else cnt_d = cnt_q - 1'b1;
      end
      S_NEXT: begin
        if (e_q[0]) r_d = p1_q;
        b_d = p2_q;
        e_d = e_q >> 1;
        p1_d = '0; p2_d = '0; cnt_d = CW'(WIDTH - 1);
        state_d = (e_q[WIDTH-1:1] == '0) ? S_DONE : S_MULT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q <= '0; b_q <= '0; e_q <= '0; r_q <= '0;
      p1_q <= '0; p2_q <= '0; cnt_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d; b_q <= b_d; e_q <= e_d; r_q <= r_d;
      p1_q <= p1_d; p2_q <= p2_d; cnt_q <= cnt_d; err_q <= err_d;
    end
  end

  assign ready        = (state_q == S_IDLE);
  assign result_valid = (state_q == S_DONE);
  assign result       = (result_valid && !err_q) ? r_q : '0;
  assign err          = result_valid & err_q;
endmodule
